// File: rtl/instruction_fetch.sv
// Instruction fetch stage: program counter, instruction register and the
// instruction-read handshake with RAM. The latched instruction is split into
// opcode and register fields for the controller and datapath.
module instruction_fetch #(
  parameter int OPCODE_WIDTH = 3,
  parameter int FIELD_WIDTH  = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic                                  Clk,
  input  logic                                  Reset_n,
  input  logic                                  PC_Clr,
  input  logic                                  PC_Load,
  input  logic                                  PC_Inc,
  input  logic                                  IR_Load,
  input  logic                                  Inst_Ack,
  input  logic [OPCODE_WIDTH+3*FIELD_WIDTH-1:0] Inst_Data,
  output logic                                  Inst_Req,
  output logic [FIELD_WIDTH-1:0]                Inst_Addr,
  output logic [FIELD_WIDTH-1:0]                PC,
  output logic [OPCODE_WIDTH-1:0]               Opcode,
  output logic [FIELD_WIDTH-1:0]                Dest_Reg,
  output logic [FIELD_WIDTH-1:0]                Source_Reg1,
  output logic [FIELD_WIDTH-1:0]                Source_Reg2,
  output logic                                  Busy,
  output logic                                  Fetch_Done,
  output logic                                  Fetch_Err
);

  localparam int INST_W = OPCODE_WIDTH + 3 * FIELD_WIDTH;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE, ERR} state_t;

  state_t             state, next_state;
  logic [INST_W-1:0]  ir;
  logic [CNT_W-1:0]   wait_cnt;
  logic               timed_out;
  logic               enter_fetch;

  // The last permitted wait cycle; an Ack arriving in it still wins.
  assign timed_out   = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign enter_fetch = (state != FETCH) && (next_state == FETCH);

  // Fields are fixed slices of the instruction register, so they only move when IR does.
  assign Opcode      = ir[INST_W-1 -: OPCODE_WIDTH];
  assign Dest_Reg    = ir[3*FIELD_WIDTH-1 -: FIELD_WIDTH];
  assign Source_Reg1 = ir[2*FIELD_WIDTH-1 -: FIELD_WIDTH];
  assign Source_Reg2 = ir[FIELD_WIDTH-1:0];

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic; IR_Load is only honoured outside FETCH
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (IR_Load) next_state = FETCH;
      FETCH: begin
        if (Inst_Ack)       next_state = DONE;
        else if (timed_out) next_state = ERR;
      end
      DONE:    next_state = IR_Load ? FETCH : IDLE;
      ERR:     next_state = IR_Load ? FETCH : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    Inst_Req   = 1'b0;
    Busy       = 1'b0;
    Fetch_Done = 1'b0;
    Fetch_Err  = 1'b0;
    case (state)
      FETCH: begin
        Inst_Req = 1'b1;
        Busy     = 1'b1;
      end
      DONE:    Fetch_Done = 1'b1;
      ERR:     Fetch_Err  = 1'b1;
      default: ;
    endcase
  end

  // Program counter with clear > load > increment priority, active in every state
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)     PC <= '0;
    else if (PC_Clr)  PC <= '0;
    else if (PC_Load) PC <= Dest_Reg;
    else if (PC_Inc)  PC <= PC + FIELD_WIDTH'(1);
  end

  // Capture the request address from the pre-update PC when a fetch starts
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)         Inst_Addr <= '0;
    else if (enter_fetch) Inst_Addr <= PC;
  end

  // Wait-cycle counter, restarted on each fetch
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                        wait_cnt <= '0;
    else if (enter_fetch)                wait_cnt <= '0;
    else if (state == FETCH && !Inst_Ack) wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Instruction register: RAM word on Ack, all-zero word on timeout
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ir <= '0;
    end else if (state == FETCH) begin
      if (Inst_Ack)       ir <= Inst_Data;
      else if (timed_out) ir <= '0;
    end
  end

endmodule
